// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline with stall_o
// for LATENCY cycles per access, then pulses ack_o with the load data or an error.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, wr_q, err_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req, accept, enterDone;
  logic          effRd, effWr, effErr;
  logic [31:0]   effAddr, effWdata;
  logic [IW-1:0] effIdx;

  assign req = MemRead_i | MemWrite_i;

  // With LATENCY=1 the access completes on the accept edge itself, so the
  // live inputs stand in for the latched copies while still in IDLE.
  always_comb begin
    effRd    = rd_q;
    effWr    = wr_q;
    effAddr  = addr_q;
    effWdata = wdata_q;
    if (state_q == IDLE) begin
      effRd    = MemRead_i;
      effWr    = MemWrite_i;
      effAddr  = addr_i;
      effWdata = wdata_i;
    end
  end

  assign effErr = (effAddr[1:0] != 2'b00) ||
                  (effAddr[31:2] >= 30'(DEPTH_WORDS)) ||
                  (effRd && effWr);
  assign effIdx = effAddr[IW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    stall_o = 1'b0;
    ack_o   = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          accept  = 1'b1;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        ack_o   = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enterDone = (state_d == DONE);
  assign rdata_o   = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q    <= MemRead_i;
        wr_q    <= MemWrite_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (enterDone) begin
        err_q   <= effErr;
        rdata_q <= (effRd && !effErr) ? mem_q[effIdx] : '0;
      end
    end
  end

  // Storage is never reset; a reset edge also suppresses a store that would commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enterDone && effWr && !effErr) begin
      mem_q[effIdx] <= effWdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table on a LATENCY=3 instance,
// plus hand sequences for reset abort, DONE hold-off and a LATENCY=1 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rstA, rdA, wrA;
  logic [31:0] addrA, wdataA, rdataA;
  logic        stallA, ackA, errA;
  logic        rstB, rdB, wrB;
  logic [31:0] addrB, wdataB, rdataB;
  logic        stallB, ackB, errB;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        scramble;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dutA (
    .clk_i(clk), .rst_i(rstA), .MemRead_i(rdA), .MemWrite_i(wrA),
    .addr_i(addrA), .wdata_i(wdataA), .stall_o(stallA), .ack_o(ackA),
    .rdata_o(rdataA), .err_o(errA)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dutB (
    .clk_i(clk), .rst_i(rstB), .MemRead_i(rdB), .MemWrite_i(wrB),
    .addr_i(addrB), .wdata_i(wdataB), .stall_o(stallB), .ack_o(ackB),
    .rdata_o(rdataB), .err_o(errB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    rdA    = rd;
    wrA    = wr;
    addrA  = addr;
    wdataA = wdata;
  endtask

  task automatic applyStimulusB(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata);
    rdB    = rd;
    wrB    = wr;
    addrB  = addr;
    wdataB = wdata;
  endtask

  // One access on dutA: accept in cycle T, ends sampling the DONE cycle T+3.
  task automatic runTxn(input vec_t v);
    @(posedge clk); #1;
    applyStimulus(v.rd, v.wr, v.addr, v.wdata);
    @(negedge clk);
    checkOutput({v.name, " stall T"}, 32'(stallA), 32'd1);
    checkOutput({v.name, " ack T"}, 32'(ackA), 32'd0);
    @(posedge clk); #1;
    if (v.scramble) applyStimulus(v.wr, v.rd, v.addr + 32'd4, ~v.wdata);
    @(negedge clk);
    checkOutput({v.name, " stall T+1"}, 32'(stallA), 32'd1);
    @(negedge clk);
    checkOutput({v.name, " stall T+2"}, 32'(stallA), 32'd1);
    checkOutput({v.name, " ack T+2"}, 32'(ackA), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput({v.name, " stall done"}, 32'(stallA), 32'd0);
    checkOutput({v.name, " ack done"}, 32'(ackA), 32'd1);
    checkOutput({v.name, " err done"}, 32'(errA), 32'(v.expErr));
    checkOutput({v.name, " rdata done"}, rdataA, v.expRdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic sawAck;

    vecs[0]  = '{"st 0x10",      1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"ld 0x10",      1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{"ld misalign",  1'b1, 1'b0, 32'h12,  32'h0,        1'b0, 1'b1, 32'h0};
    vecs[3]  = '{"st 0x0",       1'b0, 1'b1, 32'h0,   32'h11111111, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"st 0x8",       1'b0, 1'b1, 32'h8,   32'h22222222, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"st 0x400 oor", 1'b0, 1'b1, 32'h400, 32'hBADBAD00, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{"ld 0x0",       1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h11111111};
    vecs[7]  = '{"rd+wr 0x8",    1'b1, 1'b1, 32'h8,   32'h33333333, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{"ld 0x8",       1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 1'b0, 32'h22222222};
    vecs[9]  = '{"st 0x3FC",     1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"ld 0x3FC",     1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{"ld 0x400 oor", 1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[12] = '{"st 0x24 scr",  1'b0, 1'b1, 32'h24,  32'h5A5A5A5A, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{"ld 0x24 scr",  1'b1, 1'b0, 32'h24,  32'h0,        1'b1, 1'b0, 32'h5A5A5A5A};
    vecs[14] = '{"st 0x20",      1'b0, 1'b1, 32'h20,  32'h77777777, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{"ld 0x20",      1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b0, 32'h77777777};

    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulusB(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    @(negedge clk);
    checkOutput("A reset stall", 32'(stallA), 32'd0);
    checkOutput("A reset ack", 32'(ackA), 32'd0);
    checkOutput("A reset err", 32'(errA), 32'd0);
    checkOutput("A reset rdata", rdataA, 32'd0);
    checkOutput("B reset stall", 32'(stallB), 32'd0);
    checkOutput("B reset ack", 32'(ackB), 32'd0);
    checkOutput("B reset rdata", rdataB, 32'd0);

    for (int i = 0; i < 16; i++) runTxn(vecs[i]);

    // Idle with no request: flags low, last load data held.
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("idle stall", 32'(stallA), 32'd0);
    checkOutput("idle ack", 32'(ackA), 32'd0);
    checkOutput("idle err", 32'(errA), 32'd0);
    checkOutput("idle rdata hold", rdataA, 32'h77777777);
    @(negedge clk);
    checkOutput("idle rdata hold 2", rdataA, 32'h77777777);

    // Request left high through DONE must not start a second access.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("hold stall T+2", 32'(stallA), 32'd1);
    @(negedge clk);
    checkOutput("hold ack", 32'(ackA), 32'd1);
    checkOutput("hold stall done", 32'(stallA), 32'd0);
    checkOutput("hold rdata", rdataA, 32'hDEADBEEF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("no reaccept stall", 32'(stallA), 32'd0);
    checkOutput("no reaccept ack", 32'(ackA), 32'd0);

    // Reset in the second stall cycle aborts a store.
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h00001234);
    @(negedge clk);
    checkOutput("abort stall T", 32'(stallA), 32'd1);
    @(posedge clk); #1;
    rstA = 1'b1;
    @(negedge clk);
    checkOutput("abort stall T+1", 32'(stallA), 32'd1);
    @(posedge clk); #1;
    rstA = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("abort stall after", 32'(stallA), 32'd0);
    checkOutput("abort rdata after", rdataA, 32'd0);
    sawAck = ackA;
    repeat (4) begin
      @(negedge clk);
      sawAck = sawAck | ackA;
    end
    checkOutput("abort ack never", 32'(sawAck), 32'd0);
    runTxn('{"ld 0x20 post-abort", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h77777777});

    // LATENCY=1 with a store held high: accept, complete, accept, ...
    @(posedge clk); #1;
    applyStimulusB(1'b0, 1'b1, 32'h4, 32'hABCD0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("L1 stall c%0d", i), 32'(stallB), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("L1 ack c%0d", i), 32'(ackB), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    applyStimulusB(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("L1 idle stall", 32'(stallB), 32'd0);
    @(posedge clk); #1;
    applyStimulusB(1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    checkOutput("L1 ld stall", 32'(stallB), 32'd1);
    @(posedge clk); #1;
    applyStimulusB(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("L1 ld ack", 32'(ackB), 32'd1);
    checkOutput("L1 ld err", 32'(errB), 32'd0);
    checkOutput("L1 ld rdata", rdataB, 32'hABCD0001);

    // LATENCY=1 misaligned load errors after a single stall cycle.
    @(posedge clk); #1;
    applyStimulusB(1'b1, 1'b0, 32'h5, 32'h0);
    @(negedge clk);
    checkOutput("L1 err stall", 32'(stallB), 32'd1);
    @(posedge clk); #1;
    applyStimulusB(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("L1 err ack", 32'(ackB), 32'd1);
    checkOutput("L1 err err", 32'(errB), 32'd1);
    checkOutput("L1 err rdata", rdataB, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
